// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM states and lane helpers shared by the load/store path
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lo;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] a,
                                                 input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        return (sz == SZ_BYTE) ? {{24{sgn & b[7]}}, b} :
               (sz == SZ_HALF) ? {{16{sgn & h[15]}}, h} : w;
    endfunction

    // only the addressed lane is replaced; every other bit of old passes through
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] a, input logic [1:0] sz);
        logic [31:0] m;
        m = old;
        if (sz == SZ_BYTE)
            m[{a, 3'b000} +: 8] = wd[7:0];
        else if (sz == SZ_HALF)
            m[{a[1], 4'b0000} +: 16] = wd[15:0];
        else
            m = wd;
        return m;
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request port and memory_integrated port group
interface mem_access_unit_if;
    logic        cpu_req, cpu_we, cpu_signed, cpu_done, cpu_err, cpu_stall;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_rst;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_done, cpu_err, cpu_stall, mem_addr, mem_wdata, mem_we, mem_rst
    );
    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_done, cpu_err, cpu_stall, mem_addr, mem_wdata, mem_we, mem_rst
    );
endinterface

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: combinational lane extract (loads) and merge (read-modify-write stores)
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    assign rdata  = lane_extract(word, addr_lo, size, sgn);
    assign merged = lane_merge(word, wdata, addr_lo, size);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences byte/half/word loads and stores onto a word-wide BRAM port,
// waiting out the read latency and using read-modify-write for sub-word stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int          RD_LAT  = 1,
    parameter logic [31:0] IO_BASE = 32'h0000_2000
) (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave bus
);
    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t      state, state_d;
    req_t        req, req_d;
    logic [1:0]  cnt, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        we_q, we_d, done_q, done_d, err_q, err_d;
    logic [31:0] lane_rdata, lane_merged;
    logic        mis;

    mem_lane_unit u_lane (
        .word(bus.mem_rdata), .wdata(req.wdata), .addr_lo(req.lo), .size(req.size),
        .sgn(req.sgn), .rdata(lane_rdata), .merged(lane_merged)
    );

    assign mis = ((bus.cpu_size == SZ_HALF) & bus.cpu_addr[0]) |
                 ((bus.cpu_size >= SZ_WORD) & (bus.cpu_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            req     <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            req     <= req_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        req_d   = req;
        cnt_d   = cnt;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: if (bus.cpu_req) begin
                req_d  = '{we: bus.cpu_we, size: bus.cpu_size, sgn: bus.cpu_signed,
                           lo: bus.cpu_addr[1:0], wdata: bus.cpu_wdata};
                addr_d = {bus.cpu_addr[31:2], 2'b00};
                cnt_d  = '0;
                if (mis) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                // peripherals take the raw store and are never read back for a merge
                end else if (bus.cpu_we && (bus.cpu_size >= SZ_WORD || bus.cpu_addr >= IO_BASE)) begin
                    wdata_d = bus.cpu_wdata;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end else
                    state_d = RD_WAIT;
            end
            RD_WAIT: if (cnt == LAT_M1) begin
                if (req.we) begin
                    wdata_d = lane_merged;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end else begin
                    rdata_d = lane_rdata;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end else
                cnt_d = cnt + 2'd1;
            WRITE: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_err   = err_q;
    assign bus.cpu_stall = bus.cpu_req & ~done_q;
    assign bus.mem_rst   = ~rst;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, hand-written corner sequences and
// random traffic checked against a byte-arithmetic reference memory.
module tb_mem_access_unit;
    localparam int          RD_LAT  = 2;
    localparam logic [31:0] IO_BASE = 32'h0000_2000;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a, wd, rd;
        logic        er;
        int          lat, nwe;
        logic [31:0] ew;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, mem_clr = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus();
    mem_access_unit #(.RD_LAT(RD_LAT), .IO_BASE(IO_BASE)) dut (.clk(clk), .rst(rst), .bus(bus));

    // memory_integrated stand-in: registered read, so data follows the address by one edge
    logic [31:0] mem [4096];
    logic [31:0] ref_mem [4096];
    logic [31:0] rd_q;
    assign bus.mem_rdata = rd_q;
    always @(posedge clk) begin
        if (mem_clr)
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        else if (bus.mem_we)
            mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
        rd_q <= mem[bus.mem_addr[13:2]];
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input bit drop, output logic [31:0] rd, output logic er,
                        output int lat, output int nwe, output int nst, output logic [31:0] wa,
                        output logic [31:0] wdat);
        logic done;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_size = sz; bus.cpu_signed = sg;
        bus.cpu_addr = a; bus.cpu_wdata = wd;
        done = 1'b0; lat = 0; nwe = 0; nst = 0; wa = '0; wdat = '0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (drop) bus.cpu_req = 1'b0;
            if (bus.mem_we) begin nwe++; wa = bus.mem_addr; wdat = bus.mem_wdata; end
            if (bus.cpu_stall) nst++;
            done = bus.cpu_done;
        end
        chk("done_seen", 32'(done), 32'd1);
        rd = bus.cpu_rdata;
        er = bus.cpu_err;
        bus.cpu_req = 1'b0;
    endtask

    // reference: byte lanes from plain shifts/masks, then updates ref_mem
    task automatic model(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] erd, output logic eer,
                         output int elat, output int enwe, output logic [31:0] eword);
        int nb, sh;
        logic [31:0] mask, old, v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        sh = int'(a[1:0]) * 8;
        mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
        old = ref_mem[a[13:2]];
        eer = (a % nb) != 0;
        erd = '0; enwe = 0; eword = old;
        if (eer)
            elat = 1;
        else if (!we) begin
            v = (old >> sh) & mask;
            if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            erd = v;
            elat = RD_LAT + 1;
        end else if (nb == 4 || a >= IO_BASE) begin
            eword = wd; enwe = 1; elat = 2;
            ref_mem[a[13:2]] = wd;
        end else begin
            eword = (old & ~(mask << sh)) | ((wd & mask) << sh);
            enwe = 1; elat = RD_LAT + 2;
            ref_mem[a[13:2]] = eword;
        end
    endtask

    vec_t tbl[20];

    initial begin
        logic [31:0] rd, wa, wdat, erd, eword, a, wd;
        logic er, eer, we, sg;
        logic [1:0] sz;
        int lat, nwe, nst, elat, enwe, cnt_we, cnt_done;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h40,   32'h8899AABB, 32'h0,        1'b0, 2, 1, 32'h8899AABB};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 32'h44,   32'h00008000, 32'h0,        1'b0, 2, 1, 32'h00008000};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h41,   32'h0,        32'hFFFFFFAA, 1'b0, 3, 0, 32'h0};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h42,   32'h0,        32'h00008899, 1'b0, 3, 0, 32'h0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h43,   32'h0,        32'h00000088, 1'b0, 3, 0, 32'h0};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h40,   32'h0,        32'hFFFFAABB, 1'b0, 3, 0, 32'h0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h45,   32'h0,        32'hFFFFFF80, 1'b0, 3, 0, 32'h0};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h40,   32'h11223344, 32'h0,        1'b0, 2, 1, 32'h11223344};
        tbl[8]  = '{1'b1, 2'd0, 1'b0, 32'h43,   32'hFFFFFF5A, 32'h0,        1'b0, 4, 1, 32'h5A223344};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h5A223344, 1'b0, 3, 0, 32'h0};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h41,   32'h0000FFFF, 32'h0,        1'b1, 1, 0, 32'h0};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h46,   32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h5A223344, 1'b0, 3, 0, 32'h0};
        tbl[13] = '{1'b1, 2'd0, 1'b0, 32'h2001, 32'h00000007, 32'h0,        1'b0, 2, 1, 32'h00000007};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h2000, 32'h0,        32'h00000007, 1'b0, 3, 0, 32'h0};
        tbl[15] = '{1'b1, 2'd1, 1'b0, 32'h42,   32'h1234BEEF, 32'h0,        1'b0, 4, 1, 32'hBEEF3344};
        tbl[16] = '{1'b0, 2'd1, 1'b1, 32'h42,   32'h0,        32'hFFFFBEEF, 1'b0, 3, 0, 32'h0};
        tbl[17] = '{1'b1, 2'd3, 1'b0, 32'h48,   32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 32'hCAFEF00D};
        tbl[18] = '{1'b0, 2'd3, 1'b0, 32'h48,   32'h0,        32'hCAFEF00D, 1'b0, 3, 0, 32'h0};
        tbl[19] = '{1'b0, 2'd0, 1'b1, 32'h2001, 32'h0,        32'h00000000, 1'b0, 3, 0, 32'h0};

        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'd0; bus.cpu_signed = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst cpu_done", 32'(bus.cpu_done), 32'h0);
        chk("rst cpu_err", 32'(bus.cpu_err), 32'h0);
        chk("rst cpu_stall", 32'(bus.cpu_stall), 32'h0);
        chk("rst mem_rst", 32'(bus.mem_rst), 32'h1);
        mem_clr = 1'b0;
        rst = 1'b1;
        #1;
        chk("run mem_rst", 32'(bus.mem_rst), 32'h0);

        for (int i = 0; i < 20; i++) begin
            xact(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, 1'b0, rd, er, lat, nwe, nst, wa, wdat);
            chk($sformatf("v%0d err", i), 32'(er), 32'(tbl[i].er));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("v%0d mem_we cycles", i), 32'(nwe), 32'(tbl[i].nwe));
            if (!tbl[i].we || tbl[i].er) chk($sformatf("v%0d rdata", i), rd, tbl[i].rd);
            if (tbl[i].nwe != 0) begin
                chk($sformatf("v%0d mem_wdata", i), wdat, tbl[i].ew);
                chk($sformatf("v%0d mem_addr", i), wa, {tbl[i].a[31:2], 2'b00});
            end
        end

        // request dropped right after acceptance still completes its RMW
        model(1'b1, 2'd2, 1'b0, 32'h500, 32'h01020304, erd, eer, elat, enwe, eword);
        xact(1'b1, 2'd2, 1'b0, 32'h500, 32'h01020304, 1'b0, rd, er, lat, nwe, nst, wa, wdat);
        model(1'b1, 2'd0, 1'b0, 32'h502, 32'h000000AB, erd, eer, elat, enwe, eword);
        xact(1'b1, 2'd0, 1'b0, 32'h502, 32'h000000AB, 1'b1, rd, er, lat, nwe, nst, wa, wdat);
        chk("drop latency", 32'(lat), 32'(elat));
        chk("drop mem_we cycles", 32'(nwe), 32'd1);
        chk("drop mem word", mem[32'h500 >> 2], 32'h01AB0304);

        // reset asserted while a sub-word store waits on its read
        model(1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF, erd, eer, elat, enwe, eword);
        xact(1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF, 1'b0, rd, er, lat, nwe, nst, wa, wdat);
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'd0; bus.cpu_signed = 1'b0;
        bus.cpu_addr = 32'h81; bus.cpu_wdata = 32'h55;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst mem_we", 32'(bus.mem_we), 32'h0);
        chk("arst mem_addr", bus.mem_addr, 32'h0);
        chk("arst mem_wdata", bus.mem_wdata, 32'h0);
        chk("arst cpu_done", 32'(bus.cpu_done), 32'h0);
        bus.cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        cnt_we = 0; cnt_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.mem_we) cnt_we++;
            if (bus.cpu_done) cnt_done++;
        end
        chk("post-rst mem_we cycles", 32'(cnt_we), 32'h0);
        chk("post-rst cpu_done cycles", 32'(cnt_done), 32'h0);
        chk("post-rst word", mem[32'h80 >> 2], 32'hDEADBEEF);
        xact(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 1'b0, rd, er, lat, nwe, nst, wa, wdat);
        chk("post-rst load", rd, 32'hDEADBEEF);
        chk("post-rst latency", 32'(lat), 32'(RD_LAT + 1));

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) != 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                              : 32'h2100 + 32'($urandom_range(0, 31));
            wd = $urandom;
            model(we, sz, sg, a, wd, erd, eer, elat, enwe, eword);
            xact(we, sz, sg, a, wd, 1'b0, rd, er, lat, nwe, nst, wa, wdat);
            chk($sformatf("r%0d err", i), 32'(er), 32'(eer));
            chk($sformatf("r%0d latency", i), 32'(lat), 32'(elat));
            chk($sformatf("r%0d mem_we cycles", i), 32'(nwe), 32'(enwe));
            chk($sformatf("r%0d stall cycles", i), 32'(nst), 32'(elat - 1));
            if (!we || eer) chk($sformatf("r%0d rdata", i), rd, erd);
            if (enwe != 0) begin
                chk($sformatf("r%0d mem_wdata", i), wdat, eword);
                chk($sformatf("r%0d mem_addr", i), wa, {a[31:2], 2'b00});
            end
            if (we) chk($sformatf("r%0d mem word", i), mem[a[13:2]], ref_mem[a[13:2]]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the CPU execute stage and memory_integrated; drives the dataInVirt / addressVirt / wEnVirt / rstVirt port group and consumes dataOutVirt.
- Converts byte, half and word loads/stores into the word-wide accesses memory_integrated accepts, using read-modify-write for sub-word stores.
- Waits out the synchronous BRAM read latency and stalls the CPU until each access completes; detects misaligned accesses.

Parameters:
- RD_LAT, 1, cycles from mem_addr valid to mem_rdata valid (1..3).
- IO_BASE, 32'h0000_2000, addresses >= IO_BASE are peripheral space: never read-modify-written.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request; held high with fields stable until cpu_done
- cpu_we  in  1  1=store, 0=load
- cpu_size  in  2  00=byte, 01=half, 10=word (11 treated as word)
- cpu_signed  in  1  sign-extend sub-word loads
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_rdata  out  32  load result, valid while cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  misaligned access, pulses with cpu_done
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational)
- mem_addr  out  32  to addressVirt, always {cpu_addr[31:2],2'b00}
- mem_wdata  out  32  to dataInVirt
- mem_we  out  1  to wEnVirt
- mem_rst  out  1  to rstVirt; active-high, = ~rst
- mem_rdata  in  32  from dataOutVirt

Behaviour:
- Reset: state=IDLE; mem_addr, mem_wdata, cpu_rdata = 0; mem_we, cpu_done, cpu_err = 0. Async assertion mid-transaction drops mem_we immediately; no partial write is completed after release.
- Outputs are registered except cpu_stall and mem_rst.
- FSM states: IDLE, RD_WAIT, WRITE, DONE.
- IDLE, cpu_req=1: latch all request fields; cycle of acceptance = cycle 0.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with cpu_err=1; mem_we never asserts; cpu_rdata=0.
  - Load: drive mem_addr; go to RD_WAIT.
  - Word store, or any store with addr>=IO_BASE: mem_wdata=cpu_wdata, mem_we=1; go to WRITE.
  - Sub-word store below IO_BASE: drive mem_addr; go to RD_WAIT.
- RD_WAIT: counter runs RD_LAT cycles, then mem_rdata is sampled.
  - Load: extract lane, extend, register into cpu_rdata; go to DONE.
  - Sub-word store: merge cpu_wdata lane into the sampled word; mem_we=1; go to WRITE.
- WRITE: mem_we high for exactly this one cycle; go to DONE.
- DONE: cpu_done=1 for one cycle; go to IDLE.
- Latency from acceptance to cpu_done: load RD_LAT+1; word/IO store 2; sub-word store RD_LAT+2; misaligned 1.
- Lanes are little-endian. Byte k=addr[1:0] is data[8k+7:8k]; half h=addr[1] is data[16h+15:16h]. Sub-word loads zero- or sign-extend per cpu_signed. Loads in IO space use the same lane extraction.
- cpu_req dropping mid-transaction does not abort: the memory write still occurs and cpu_done still pulses.
- Back-to-back requests: a new request is sampled only in IDLE, so the minimum gap is one cycle after cpu_done.
- Merge preserves the untouched bytes bit-exactly; no other byte of the word changes.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum
  - function lane_extract(word, addr_lo, size, signed)
  - function lane_merge(old, wdata, addr_lo, size)
- One sub-module is natural: mem_lane_unit, the combinational extract/merge datapath shared by the load and RMW paths. The FSM stays in mem_access_unit.

Test Plan:
- Word at 0x40 = 0x8899AABB; load byte signed at 0x41 -> cpu_rdata=0xFFFFFFAA, cpu_done at cycle RD_LAT+1, mem_we stays 0.
- Same word; load half unsigned at 0x42 -> cpu_rdata=0x00008899.
- Store byte 0x5A at 0x43 over 0x11223344 -> one read, mem_we one cycle with mem_wdata=0x5A223344, done at cycle RD_LAT+2; reload word at 0x40 -> 0x5A223344.
- Store half at 0x41 -> cpu_err=1 and cpu_done in cycle 1, no mem_we, memory unchanged; load word at 0x46 -> same error behaviour.
- Store byte 0x07 at IO_BASE+1 -> no read phase, single mem_we with mem_wdata=0x00000007 at mem_addr=IO_BASE, done at cycle 2.
- Assert rst low during RD_WAIT of a sub-word store -> outputs zero immediately, no mem_we after release, target word unchanged; the next load completes normally.
